// File: rtl/datapath_regbank_if.sv
// Control word, bus and memory signals between the control unit and the register bank.
interface datapath_regbank_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned IR_W   = 8
) ();
    logic [2:0]        bflag;
    logic [7:0]        cflag;
    logic              pcinc;
    logic              r1inc;
    logic              r2inc;
    logic              r3inc;
    logic              acinc;
    logic              fetch;
    logic              finish;
    logic [DATA_W-1:0] c_bus;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] b_bus;
    logic [DATA_W-1:0] ac;
    logic [IR_W-1:0]   ir;
    logic              z;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;

    // Control unit / ALU / memory side.
    modport master (
        output bflag, cflag, pcinc, r1inc, r2inc, r3inc, acinc, fetch, finish,
        output c_bus, mem_rdata,
        input  b_bus, ac, ir, z, mem_addr, mem_wdata, mem_we
    );

    // Register bank side.
    modport slave (
        input  bflag, cflag, pcinc, r1inc, r2inc, r3inc, acinc, fetch, finish,
        input  c_bus, mem_rdata,
        output b_bus, ac, ir, z, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/datapath_regbank.sv
// Datapath register bank: AR, PC, R1-R3, R, AC and IR, with B-bus steering into the ALU,
// C-bus write-back and data-memory address/write strobe.
module datapath_regbank #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned IR_W   = 8
) (
    input logic              clk,
    input logic              rst,
    datapath_regbank_if.slave bus
);
    // Common width so AR can take c_bus zero-extended or truncated.
    localparam int unsigned EXT_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

    logic [ADDR_W-1:0] ar_q;
    logic [DATA_W-1:0] pc_q, r1_q, r2_q, r3_q, r_q, ac_q;
    logic [IR_W-1:0]   ir_q;
    logic [EXT_W-1:0]  c_ext;
    logic [ADDR_W-1:0] ar_load;

    assign c_ext   = EXT_W'(bus.c_bus);
    assign ar_load = c_ext[ADDR_W-1:0];

    // Register updates: reset beats finish, finish freezes everything, a load beats an increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            ar_q <= '0;
            pc_q <= '0;
            r1_q <= '0;
            r2_q <= '0;
            r3_q <= '0;
            r_q  <= '0;
            ac_q <= '0;
            ir_q <= '0;
        end else if (!bus.finish) begin
            if (bus.cflag[7]) ar_q <= ar_load;

            if (bus.cflag[6])   pc_q <= bus.c_bus;
            else if (bus.pcinc) pc_q <= pc_q + ONE;

            if (bus.cflag[5])   r1_q <= bus.c_bus;
            else if (bus.r1inc) r1_q <= r1_q + ONE;

            if (bus.cflag[4])   r2_q <= bus.c_bus;
            else if (bus.r2inc) r2_q <= r2_q + ONE;

            if (bus.cflag[3])   r3_q <= bus.c_bus;
            else if (bus.r3inc) r3_q <= r3_q + ONE;

            if (bus.cflag[2]) r_q <= bus.c_bus;

            if (bus.cflag[1])   ac_q <= bus.c_bus;
            else if (bus.acinc) ac_q <= ac_q + ONE;

            if (bus.fetch) ir_q <= bus.mem_rdata[IR_W-1:0];
        end
    end

    // B-bus source select into the ALU.
    always_comb begin
        bus.b_bus = '0;
        case (bus.bflag)
            3'd0:    bus.b_bus = '0;
            3'd1:    bus.b_bus = pc_q;
            3'd2:    bus.b_bus = r1_q;
            3'd3:    bus.b_bus = r2_q;
            3'd4:    bus.b_bus = r3_q;
            3'd5:    bus.b_bus = r_q;
            3'd6:    bus.b_bus = ac_q;
            default: bus.b_bus = bus.mem_rdata;
        endcase
    end

    // Outputs derived directly from registered state and the current control word.
    always_comb begin
        bus.ac        = ac_q;
        bus.ir        = ir_q;
        bus.z         = (ac_q == '0);
        bus.mem_addr  = ar_q;
        bus.mem_wdata = bus.c_bus;
        bus.mem_we    = bus.cflag[0] & ~bus.finish & ~rst;
    end
endmodule

// File: tb/tb_datapath_regbank.sv
// Directed self-checking bench for datapath_regbank. Inputs change 1ns after the rising edge.
module tb_datapath_regbank;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    datapath_regbank_if bus_if ();

    datapath_regbank dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic idle();
        bus_if.bflag  = 3'd0;
        bus_if.cflag  = 8'h00;
        bus_if.pcinc  = 1'b0;
        bus_if.r1inc  = 1'b0;
        bus_if.r2inc  = 1'b0;
        bus_if.r3inc  = 1'b0;
        bus_if.acinc  = 1'b0;
        bus_if.fetch  = 1'b0;
        bus_if.finish = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observe a register through the B-bus mux.
    task automatic peek(input logic [2:0] sel, output logic [15:0] v);
        bus_if.bflag = sel;
        #1;
        v = bus_if.b_bus;
    endtask

    task automatic load(input logic [7:0] cf, input logic [15:0] val);
        bus_if.cflag = cf;
        bus_if.c_bus = val;
        tick();
        bus_if.cflag = 8'h00;
    endtask

    task automatic test_reset();
        logic [15:0] v;
        idle();
        rst = 1'b1;
        bus_if.cflag     = 8'hFF;
        bus_if.c_bus     = 16'h1234;
        bus_if.pcinc     = 1'b1;
        bus_if.fetch     = 1'b1;
        bus_if.mem_rdata = 16'hABCD;
        #1;
        checks++;
        if (bus_if.mem_we !== 1'b0) begin
            errors++; $display("FAIL reset_we got %b want 0", bus_if.mem_we);
        end
        tick();
        tick();
        for (int s = 1; s <= 6; s++) begin
            peek(3'(s), v);
            checks++;
            if (v !== 16'h0000) begin
                errors++; $display("FAIL reset_reg%0d got %h want 0000", s, v);
            end
        end
        checks++;
        if (bus_if.z !== 1'b1 || bus_if.mem_addr !== 16'h0000 || bus_if.ir !== 8'h00) begin
            errors++;
            $display("FAIL reset_out got z=%b addr=%h ir=%h want 1 0000 00",
                     bus_if.z, bus_if.mem_addr, bus_if.ir);
        end
        rst = 1'b0;
        bus_if.pcinc = 1'b0;
        bus_if.fetch = 1'b0;
        #1;
        checks++;
        if (bus_if.mem_we !== 1'b1) begin
            errors++; $display("FAIL release_we got %b want 1", bus_if.mem_we);
        end
        tick();
        bus_if.cflag = 8'h00;
        for (int s = 1; s <= 6; s++) begin
            peek(3'(s), v);
            checks++;
            if (v !== 16'h1234) begin
                errors++; $display("FAIL release_reg%0d got %h want 1234", s, v);
            end
        end
        checks++;
        if (bus_if.mem_addr !== 16'h1234 || bus_if.ir !== 8'h00 || bus_if.z !== 1'b0) begin
            errors++;
            $display("FAIL release_out got addr=%h ir=%h z=%b want 1234 00 0",
                     bus_if.mem_addr, bus_if.ir, bus_if.z);
        end
    endtask

    task automatic test_mux_write();
        logic [15:0] v;
        logic [15:0] exp_tab [8];
        idle();
        load(8'b0010_0000, 16'h00A5);
        peek(3'd2, v);
        checks++;
        if (v !== 16'h00A5) begin
            errors++; $display("FAIL r1_write got %h want 00a5", v);
        end
        load(8'h40, 16'h1111);
        load(8'h20, 16'h2222);
        load(8'h10, 16'h3333);
        load(8'h08, 16'h4444);
        load(8'h04, 16'h5555);
        load(8'h02, 16'h6666);
        bus_if.mem_rdata = 16'h7777;
        exp_tab = '{16'h0000, 16'h1111, 16'h2222, 16'h3333,
                    16'h4444, 16'h5555, 16'h6666, 16'h7777};
        for (int s = 0; s < 8; s++) begin
            peek(3'(s), v);
            checks++;
            if (v !== exp_tab[s]) begin
                errors++; $display("FAIL bsweep%0d got %h want %h", s, v, exp_tab[s]);
            end
        end
    endtask

    task automatic test_increment();
        logic [15:0] v;
        idle();
        load(8'h40, 16'hFFFF);
        bus_if.pcinc = 1'b1;
        tick();
        bus_if.pcinc = 1'b0;
        peek(3'd1, v);
        checks++;
        if (v !== 16'h0000) begin
            errors++; $display("FAIL pc_wrap got %h want 0000", v);
        end
        bus_if.pcinc = 1'b1;
        bus_if.r1inc = 1'b1;
        bus_if.r2inc = 1'b1;
        bus_if.r3inc = 1'b1;
        tick();
        idle();
        peek(3'd1, v);
        checks++;
        if (v !== 16'h0001) begin
            errors++; $display("FAIL multi_inc_pc got %h want 0001", v);
        end
        peek(3'd2, v);
        checks++;
        if (v !== 16'h2223) begin
            errors++; $display("FAIL multi_inc_r1 got %h want 2223", v);
        end
        peek(3'd4, v);
        checks++;
        if (v !== 16'h4445) begin
            errors++; $display("FAIL multi_inc_r3 got %h want 4445", v);
        end
        bus_if.acinc = 1'b1;
        load(8'h02, 16'h0010);
        bus_if.acinc = 1'b0;
        checks++;
        if (bus_if.ac !== 16'h0010) begin
            errors++; $display("FAIL ac_load_wins got %h want 0010", bus_if.ac);
        end
        bus_if.pcinc = 1'b1;
        load(8'h40, 16'h0500);
        bus_if.pcinc = 1'b0;
        peek(3'd1, v);
        checks++;
        if (v !== 16'h0500) begin
            errors++; $display("FAIL pc_load_wins got %h want 0500", v);
        end
    endtask

    task automatic test_fetch();
        logic [15:0] v;
        idle();
        bus_if.mem_rdata = 16'h3C16;
        bus_if.fetch     = 1'b1;
        bus_if.cflag     = 8'hFE;
        bus_if.c_bus     = 16'h00AB;
        #1;
        checks++;
        if (bus_if.mem_we !== 1'b0) begin
            errors++; $display("FAIL fetch_we got %b want 0", bus_if.mem_we);
        end
        tick();
        idle();
        checks++;
        if (bus_if.ir !== 8'h16) begin
            errors++; $display("FAIL fetch_ir got %h want 16", bus_if.ir);
        end
        peek(3'd1, v);
        checks++;
        if (v !== 16'h00AB || bus_if.ac !== 16'h00AB || bus_if.mem_addr !== 16'h00AB) begin
            errors++;
            $display("FAIL fetch_loads got pc=%h ac=%h ar=%h want 00ab",
                     v, bus_if.ac, bus_if.mem_addr);
        end
    endtask

    task automatic test_zero();
        idle();
        load(8'h02, 16'h0001);
        checks++;
        if (bus_if.z !== 1'b0) begin
            errors++; $display("FAIL z_one got %b want 0", bus_if.z);
        end
        bus_if.cflag = 8'h02;
        bus_if.c_bus = 16'h0000;
        #1;
        checks++;
        if (bus_if.z !== 1'b0) begin
            errors++; $display("FAIL z_before_edge got %b want 0", bus_if.z);
        end
        tick();
        bus_if.cflag = 8'h00;
        checks++;
        if (bus_if.z !== 1'b1) begin
            errors++; $display("FAIL z_after_edge got %b want 1", bus_if.z);
        end
        bus_if.acinc = 1'b1;
        tick();
        bus_if.acinc = 1'b0;
        checks++;
        if (bus_if.z !== 1'b0 || bus_if.ac !== 16'h0001) begin
            errors++; $display("FAIL z_acinc got z=%b ac=%h want 0 0001", bus_if.z, bus_if.ac);
        end
    endtask

    task automatic test_store_finish();
        logic [15:0] v;
        idle();
        load(8'h80, 16'h0040);
        bus_if.cflag = 8'h01;
        bus_if.c_bus = 16'h0077;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (bus_if.mem_we !== 1'b1 || bus_if.mem_addr !== 16'h0040 ||
                bus_if.mem_wdata !== 16'h0077) begin
                errors++;
                $display("FAIL store_cyc%0d got we=%b addr=%h wd=%h want 1 0040 0077",
                         c, bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata);
            end
            tick();
        end
        bus_if.finish    = 1'b1;
        bus_if.cflag     = 8'hFF;
        bus_if.c_bus     = 16'hBEEF;
        bus_if.pcinc     = 1'b1;
        bus_if.r1inc     = 1'b1;
        bus_if.r2inc     = 1'b1;
        bus_if.r3inc     = 1'b1;
        bus_if.acinc     = 1'b1;
        bus_if.fetch     = 1'b1;
        bus_if.mem_rdata = 16'h1111;
        #1;
        checks++;
        if (bus_if.mem_we !== 1'b0) begin
            errors++; $display("FAIL finish_we got %b want 0", bus_if.mem_we);
        end
        tick();
        tick();
        peek(3'd1, v);
        checks++;
        if (v !== 16'h00AB || bus_if.ac !== 16'h0001 || bus_if.mem_addr !== 16'h0040 ||
            bus_if.ir !== 8'h16) begin
            errors++;
            $display("FAIL finish_freeze got pc=%h ac=%h ar=%h ir=%h want 00ab 0001 0040 16",
                     v, bus_if.ac, bus_if.mem_addr, bus_if.ir);
        end
        peek(3'd5, v);
        checks++;
        if (v !== 16'h00AB) begin
            errors++; $display("FAIL finish_freeze_r got %h want 00ab", v);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        peek(3'd1, v);
        checks++;
        if (v !== 16'h0000 || bus_if.ac !== 16'h0000 || bus_if.z !== 1'b1 ||
            bus_if.mem_addr !== 16'h0000 || bus_if.ir !== 8'h00) begin
            errors++;
            $display("FAIL finish_reset got pc=%h ac=%h z=%b ar=%h ir=%h want 0000 0000 1 0000 00",
                     v, bus_if.ac, bus_if.z, bus_if.mem_addr, bus_if.ir);
        end
        idle();
    endtask

    initial begin
        rst              = 1'b1;
        bus_if.c_bus     = 16'h0000;
        bus_if.mem_rdata = 16'h0000;
        idle();
        test_reset();
        test_mux_write();
        test_increment();
        test_fetch();
        test_zero();
        test_store_finish();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
